memory_access_stage: RTL and testbench
======================================

# memory_access_stage

Pipeline stage 3 of the RV64IM core: consumes the execute stage's result bundle (ALU result, rs2 value, destination register, opcode name) and produces the register-writeback bundle. Loads and stores go out over a valid/ready request channel and come back on a response channel, with byte-lane alignment and sign/zero extension. All other instructions pass the ALU result through. The block holds one instruction at a time and back-pressures execute while a memory access is outstanding.

## Interface
- REGISTER_NUMBER_WIDTH, 5, rd field is [REGISTER_NUMBER_WIDTH:0]
- REGISTER_WIDTH, 64, datapath width
- INSTRUCTION_NAME_WIDTH, 12, opcode name is an ASCII string [INSTRUCTION_NAME_WIDTH*8:0]
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- stage3_valid  in  1  execute bundle valid
- stage3_ready  out  1  stage can accept a bundle
- stage3_alu_result  in  REGISTER_WIDTH  ALU result or effective address
- stage3_rs2_val  in  REGISTER_WIDTH  store data
- stage3_rd  in  REGISTER_NUMBER_WIDTH+1  destination register
- stage3_opcode_name  in  INSTRUCTION_NAME_WIDTH*8+1  opcode string
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_addr  out  64  address with [2:0] forced to 0
- mem_req_write  out  1  1 = store
- mem_req_wdata  out  64  lane-shifted store data
- mem_req_wstrb  out  8  byte enables
- mem_resp_valid  in  1  load data valid (one pulse per load request)
- mem_resp_rdata  in  64  doubleword read data
- wb_valid / wb_ready  out / in  1  writeback handshake
- wb_en  out  1  register write enable
- wb_rd  out  REGISTER_NUMBER_WIDTH+1  destination register
- wb_data  out  REGISTER_WIDTH  writeback value
- wb_fault  out  1  misaligned access flag

## Operation
- Decode the opcode name at acceptance into a packed op and size:
  - Loads: lb, lh, lw, ld, lbu, lhu, lwu.
  - Stores: sb, sh, sw, sd.
  - No-write class: beq, bne, blt, bge, bltu, bgeu, fence, fencei, scall, sbreak, and any name not recognised.
  - Everything else is an ALU writeback.
- FSM states: IDLE, REQ, RESP, WB.
  - IDLE: stage3_ready=1. On stage3_valid, latch the bundle. Loads and stores go to REQ; all other ops go to WB.
  - REQ: mem_req_valid=1, request fields held stable. On mem_req_ready, a load goes to RESP and a store goes to WB.
  - RESP: wait for mem_resp_valid, then capture the aligned data and go to WB.
  - WB: wb_valid=1, outputs held stable. On wb_ready, go to IDLE.
- Lane offset off = addr[2:0].
  - Store: wdata = rs2 << 8*off. wstrb = size mask (1, 3, 0xF, 0xFF) << off, truncated to 8 bits.
  - Load: shift = rdata >> 8*off, then sign-extend for lb/lh/lw or zero-extend for lbu/lhu/lwu/ld.
- wb_en = 1 for loads and ALU ops with rd != 0; 0 for stores, the no-write class, and rd == 0.
- ALU ops: wb_data = alu_result. Stores and the no-write class: wb_data = 0.
- mem_resp_valid outside RESP is ignored.
- A response arriving in the same cycle as the request handshake is not possible: the protocol requires the response at least one cycle later.

## Timing
- Reset values: state IDLE, stage3_ready=1, mem_req_valid=0, wb_valid=0, wb_en=0, wb_fault=0, all data outputs 0.
- An assertion of reset_n low at any state aborts the instruction; a response arriving after reset is dropped.
- ALU op accepted in cycle N: wb_valid in N+1.
- Store accepted in N: mem_req_valid in N+1; if ready in N+1, wb_valid in N+2.
- Load accepted in N with zero-wait memory (ready N+1, response N+2): wb_valid in N+3.
- Each stall cycle on ready or response adds one cycle.
- All outputs are registered. No combinational path from any input to stage3_ready or to mem_req_*.
- The next bundle is accepted only in IDLE, so peak throughput is one instruction per 2 cycles.

## Configuration
- MEM_STAGE_MISALIGN_TRAP_EN defined:
  - Misalignment check applies to h, w and d accesses whose off is not a multiple of the access size.
  - A misaligned access skips REQ and goes directly to WB with wb_fault=1, wb_en=0, wb_data = faulting address.
- MEM_STAGE_MISALIGN_TRAP_EN undefined:
  - No check; wb_fault is tied to 0.
  - Misaligned accesses are issued as-is; bytes past lane 7 are dropped (wstrb truncated, load upper bytes read as 0 before extension).

## Structure
- Package mem_stage_pkg holds:
  - mem_op_e (ALU, LOAD, STORE, NOWB), mem_size_e (B, H, W, D), state_e.
  - A decode function from opcode string to op, size and unsigned flag.
  - The size-to-strobe constant.
- Sub-module load_align: combinational lane extraction plus sign/zero extension, instantiated once.

## Test plan
- addi result 0x1234, rd=5, wb_ready=1 -> wb_valid one cycle later; wb_en=1, wb_rd=5, wb_data=0x1234, no memory request.
- sb with addr 0x1003, rs2=0xAB -> mem_req_addr 0x1000, wstrb 0x08, wdata 0xAB000000; wb_en=0.
- lb at 0x2006, rdata 0x0080_0000_0000_0000 -> wb_data 0xFFFF_FFFF_FFFF_FF80. Same access as lbu -> 0x80.
- lw with mem_req_ready held low 3 cycles and response 2 cycles after the handshake -> stage3_ready=0 throughout; wb_valid after the response; single request only.
- lh at 0x3001: with the macro -> wb_fault=1, no request, wb_data 0x3001. Without the macro -> request issued with wstrb-free read; result is sign-extension of bytes 1..2.
- reset_n pulsed low while in RESP -> all outputs reset; a later mem_resp_valid is ignored; next add completes normally.

Source files
------------

// File: rtl/memory_access_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
//
// Shared types and helpers for the memory access stage (pipeline stage 3 of
// the RV64IM core).
//   - Width constants for the register file, datapath and opcode name string.
//   - mem_op_e   : what the stage does with an instruction (ALU writeback,
//                  load, store, or no register write).
//   - mem_size_e : access size of a load or store.
//   - state_e    : stage FSM states.
//   - SIZE_STRB  : byte-enable pattern of each access size at lane 0.
//   - decodeOp() : maps the ASCII opcode name to op, size and unsigned flag.
//
// Optional feature macro used by the stage: MEM_STAGE_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int REGISTER_NUMBER_WIDTH  = 5;
  localparam int REGISTER_WIDTH         = 64;
  localparam int INSTRUCTION_NAME_WIDTH = 12;

  localparam int RD_W   = REGISTER_NUMBER_WIDTH + 1;
  localparam int NAME_W = INSTRUCTION_NAME_WIDTH * 8 + 1;

  // Opcode names are right-justified ASCII with zero padding on the left.
  typedef logic [NAME_W-1:0] opName_t;

  typedef enum logic [1:0] {OP_ALU, OP_LOAD, OP_STORE, OP_NOWB} mem_op_e;
  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_D}     mem_size_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_WB}    state_e;

  typedef struct packed {
    mem_op_e   op;
    mem_size_e size;
    logic      isUnsigned;
  } memDecode_t;

  // Indexed by mem_size_e; shifted left by the lane offset before use.
  localparam logic [7:0] SIZE_STRB [4] = '{8'h01, 8'h03, 8'h0F, 8'hFF};

  // Unrecognised names fall into the no-write class so that an unknown
  // instruction can never corrupt the register file.
  function automatic memDecode_t decodeOp(input opName_t name);
    memDecode_t d;
    d.op         = OP_NOWB;
    d.size       = SIZE_D;
    d.isUnsigned = 1'b0;
    case (name)
      opName_t'("lb"):  begin d.op = OP_LOAD;  d.size = SIZE_B; end
      opName_t'("lh"):  begin d.op = OP_LOAD;  d.size = SIZE_H; end
      opName_t'("lw"):  begin d.op = OP_LOAD;  d.size = SIZE_W; end
      opName_t'("ld"):  begin d.op = OP_LOAD;  d.size = SIZE_D; end
      opName_t'("lbu"): begin d.op = OP_LOAD;  d.size = SIZE_B; d.isUnsigned = 1'b1; end
      opName_t'("lhu"): begin d.op = OP_LOAD;  d.size = SIZE_H; d.isUnsigned = 1'b1; end
      opName_t'("lwu"): begin d.op = OP_LOAD;  d.size = SIZE_W; d.isUnsigned = 1'b1; end
      opName_t'("sb"):  begin d.op = OP_STORE; d.size = SIZE_B; end
      opName_t'("sh"):  begin d.op = OP_STORE; d.size = SIZE_H; end
      opName_t'("sw"):  begin d.op = OP_STORE; d.size = SIZE_W; end
      opName_t'("sd"):  begin d.op = OP_STORE; d.size = SIZE_D; end
      opName_t'("beq"), opName_t'("bne"), opName_t'("blt"), opName_t'("bge"),
      opName_t'("bltu"), opName_t'("bgeu"), opName_t'("fence"),
      opName_t'("fencei"), opName_t'("scall"), opName_t'("sbreak"):
        d.op = OP_NOWB;
      opName_t'("lui"), opName_t'("auipc"), opName_t'("jal"), opName_t'("jalr"),
      opName_t'("addi"), opName_t'("slti"), opName_t'("sltiu"), opName_t'("xori"),
      opName_t'("ori"), opName_t'("andi"), opName_t'("slli"), opName_t'("srli"),
      opName_t'("srai"), opName_t'("add"), opName_t'("sub"), opName_t'("sll"),
      opName_t'("slt"), opName_t'("sltu"), opName_t'("xor"), opName_t'("srl"),
      opName_t'("sra"), opName_t'("or"), opName_t'("and"), opName_t'("addiw"),
      opName_t'("slliw"), opName_t'("srliw"), opName_t'("sraiw"), opName_t'("addw"),
      opName_t'("subw"), opName_t'("sllw"), opName_t'("srlw"), opName_t'("sraw"),
      opName_t'("mul"), opName_t'("mulh"), opName_t'("mulhsu"), opName_t'("mulhu"),
      opName_t'("div"), opName_t'("divu"), opName_t'("rem"), opName_t'("remu"),
      opName_t'("mulw"), opName_t'("divw"), opName_t'("divuw"), opName_t'("remw"),
      opName_t'("remuw"):
        d.op = OP_ALU;
      default:
        d.op = OP_NOWB;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// ---------------------------------------------------------------------------
// memory_access_stage_if
//
// Bundles the three channels of the memory access stage:
//   - stage3_* : execute result bundle in (valid/ready, stage is the sink)
//   - mem_req_*/mem_resp_* : memory request out, load response in
//   - wb_*     : register writeback bundle out (valid/ready)
// Modports:
//   master : the memory access stage itself
//   slave  : its environment (execute stage, memory, writeback)
// ---------------------------------------------------------------------------
interface memory_access_stage_if;
  import mem_stage_pkg::*;

  logic                      stage3_valid;
  logic                      stage3_ready;
  logic [REGISTER_WIDTH-1:0] stage3_alu_result;
  logic [REGISTER_WIDTH-1:0] stage3_rs2_val;
  logic [RD_W-1:0]           stage3_rd;
  opName_t                   stage3_opcode_name;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [63:0]               mem_req_addr;
  logic                      mem_req_write;
  logic [63:0]               mem_req_wdata;
  logic [7:0]                mem_req_wstrb;
  logic                      mem_resp_valid;
  logic [63:0]               mem_resp_rdata;

  logic                      wb_valid;
  logic                      wb_ready;
  logic                      wb_en;
  logic [RD_W-1:0]           wb_rd;
  logic [REGISTER_WIDTH-1:0] wb_data;
  logic                      wb_fault;

  modport master (
    input  stage3_valid, stage3_alu_result, stage3_rs2_val, stage3_rd,
           stage3_opcode_name,
    output stage3_ready,
    output mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata,
           mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output wb_valid, wb_en, wb_rd, wb_data, wb_fault,
    input  wb_ready
  );

  modport slave (
    output stage3_valid, stage3_alu_result, stage3_rs2_val, stage3_rd,
           stage3_opcode_name,
    input  stage3_ready,
    input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata,
           mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  wb_valid, wb_en, wb_rd, wb_data, wb_fault,
    output wb_ready
  );

endinterface

// File: rtl/memory_access_stage_load_align.sv
// ---------------------------------------------------------------------------
// load_align
//
// Combinational load data alignment: moves the addressed lane of a 64-bit
// read doubleword down to bit 0 and sign- or zero-extends it to 64 bits.
// Bytes beyond lane 7 (a misaligned access running off the doubleword) read
// as zero before extension.
// Ports:
//   i_rdata    : doubleword read data
//   i_offset   : byte lane of the access (address[2:0])
//   i_size     : access size
//   i_unsigned : 1 = zero-extend, 0 = sign-extend
//   o_data     : aligned, extended load result
// ---------------------------------------------------------------------------
module load_align
  import mem_stage_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_offset,
  input  mem_size_e   i_size,
  input  logic        i_unsigned,
  output logic [63:0] o_data
);

  logic [63:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  // Extend from the top bit of the access size; doublewords need no extension.
  always_comb begin
    o_data = w_shifted;
    case (i_size)
      SIZE_B: o_data = i_unsigned ? {56'd0, w_shifted[7:0]}
                                  : {{56{w_shifted[7]}}, w_shifted[7:0]};
      SIZE_H: o_data = i_unsigned ? {48'd0, w_shifted[15:0]}
                                  : {{48{w_shifted[15]}}, w_shifted[15:0]};
      SIZE_W: o_data = i_unsigned ? {32'd0, w_shifted[31:0]}
                                  : {{32{w_shifted[31]}}, w_shifted[31:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// ---------------------------------------------------------------------------
// memory_access_stage
//
// Pipeline stage 3 of the RV64IM core. Takes one execute bundle at a time,
// performs the load/store over the memory request/response channel with
// byte-lane alignment, and presents the register writeback bundle. Non-memory
// instructions pass the ALU result straight to writeback. Execute is
// back-pressured (stage3_ready low) whenever an instruction is in flight.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, aborts any instruction in flight
//   bus     : memory_access_stage_if.master (stage3_*, mem_req_*/mem_resp_*,
//             wb_*)
// Optional feature: MEM_STAGE_MISALIGN_TRAP_EN
//   defined   - misaligned h/w/d accesses skip memory and write back a fault
//               carrying the faulting address
//   undefined - accesses are issued as-is, wb_fault is tied to 0
// All outputs come straight from registers; no input reaches stage3_ready or
// mem_req_* combinationally.
// ---------------------------------------------------------------------------
module memory_access_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  memory_access_stage_if.master bus
);

  state_e                    r_state;
  state_e                    w_nextState;

  mem_op_e                   r_op;
  mem_size_e                 r_size;
  logic                      r_unsigned;
  logic [RD_W-1:0]           r_rd;
  logic [REGISTER_WIDTH-1:0] r_addr;
  logic                      r_reqWrite;
  logic [63:0]               r_reqWdata;
  logic [7:0]                r_reqWstrb;
  logic                      r_wbEn;
  logic [REGISTER_WIDTH-1:0] r_wbData;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic                      r_wbFault;
`endif

  memDecode_t                w_dec;
  logic                      w_accept;
  logic [2:0]                w_off;
  logic                      w_isMem;
  logic                      w_trap;
  logic                      w_wbEnNext;
  logic [15:0]               w_strbWide;
  logic [63:0]               w_storeData;
  logic [63:0]               w_loadData;

  assign w_dec       = decodeOp(bus.stage3_opcode_name);
  assign w_accept    = (r_state == ST_IDLE) && bus.stage3_valid;
  assign w_off       = bus.stage3_alu_result[2:0];
  assign w_isMem     = (w_dec.op == OP_LOAD) || (w_dec.op == OP_STORE);
  // Shift in 16 bits so strobes pushed past lane 7 fall off the top.
  assign w_strbWide  = {8'h00, SIZE_STRB[w_dec.size]} << w_off;
  assign w_storeData = bus.stage3_rs2_val << {w_off, 3'b000};

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic w_misaligned;

  // Bytes never cross a lane boundary, so only h/w/d can be misaligned.
  always_comb begin
    w_misaligned = 1'b0;
    case (w_dec.size)
      SIZE_H:  w_misaligned = w_off[0];
      SIZE_W:  w_misaligned = |w_off[1:0];
      SIZE_D:  w_misaligned = |w_off;
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_trap = w_isMem && w_misaligned;
`else
  assign w_trap = 1'b0;
`endif

  assign w_wbEnNext = !w_trap && (bus.stage3_rd != '0) &&
                      ((w_dec.op == OP_ALU) || (w_dec.op == OP_LOAD));

  load_align u_loadAlign (
    .i_rdata    (bus.mem_resp_rdata),
    .i_offset   (r_addr[2:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_loadData)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A trapped access never reaches the memory channel.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.stage3_valid) begin
          w_nextState = (w_isMem && !w_trap) ? ST_REQ : ST_WB;
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) begin
          w_nextState = (r_op == OP_LOAD) ? ST_RESP : ST_WB;
        end
      end
      ST_RESP: begin
        if (bus.mem_resp_valid) begin
          w_nextState = ST_WB;
        end
      end
      ST_WB: begin
        if (bus.wb_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Bundle capture at acceptance and load data capture on the response.
  // Everything else holds, which keeps request and writeback fields stable
  // while their handshakes are pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op       <= OP_NOWB;
      r_size     <= SIZE_B;
      r_unsigned <= 1'b0;
      r_rd       <= '0;
      r_addr     <= '0;
      r_reqWrite <= 1'b0;
      r_reqWdata <= '0;
      r_reqWstrb <= '0;
      r_wbEn     <= 1'b0;
      r_wbData   <= '0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      r_wbFault  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_op       <= w_dec.op;
      r_size     <= w_dec.size;
      r_unsigned <= w_dec.isUnsigned;
      r_rd       <= bus.stage3_rd;
      r_addr     <= bus.stage3_alu_result;
      r_reqWrite <= (w_dec.op == OP_STORE);
      r_reqWdata <= (w_dec.op == OP_STORE) ? w_storeData : '0;
      r_reqWstrb <= (w_dec.op == OP_STORE) ? w_strbWide[7:0] : '0;
      r_wbEn     <= w_wbEnNext;
      r_wbData   <= ((w_dec.op == OP_ALU) || w_trap) ? bus.stage3_alu_result : '0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      r_wbFault  <= w_trap;
`endif
    end else if ((r_state == ST_RESP) && bus.mem_resp_valid) begin
      r_wbData   <= w_loadData;
    end
  end

  assign bus.stage3_ready  = (r_state == ST_IDLE);
  assign bus.mem_req_valid = (r_state == ST_REQ);
  assign bus.mem_req_addr  = {r_addr[63:3], 3'b000};
  assign bus.mem_req_write = r_reqWrite;
  assign bus.mem_req_wdata = r_reqWdata;
  assign bus.mem_req_wstrb = r_reqWstrb;
  assign bus.wb_valid      = (r_state == ST_WB);
  assign bus.wb_en         = r_wbEn;
  assign bus.wb_rd         = r_rd;
  assign bus.wb_data       = r_wbData;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign bus.wb_fault      = r_wbFault;
`else
  assign bus.wb_fault      = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_access_stage
//
// Directed testbench for memory_access_stage. The bench plays execute,
// memory and writeback by hand, one step at a time, with expected values
// worked out from the instruction semantics. Honours
// MEM_STAGE_MISALIGN_TRAP_EN for the misaligned-access steps.
// ---------------------------------------------------------------------------
module tb_memory_access_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors     = 0;
  int   miscompares = 0;
  int   reqCount    = 0;
  int   reqBase;

  memory_access_stage_if bus();

  memory_access_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Counts accepted memory requests.
  always @(posedge clk) begin
    if (reset_n && bus.mem_req_valid && bus.mem_req_ready) reqCount++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  // Presents one bundle for a single cycle in IDLE; returns in cycle N+1.
  task automatic applyStimulus(input opName_t name, input logic [63:0] alu,
                               input logic [63:0] rs2, input logic [RD_W-1:0] rd);
    checkOutput("ready_before_accept", 64'(bus.stage3_ready), 64'd1);
    bus.stage3_opcode_name = name;
    bus.stage3_alu_result  = alu;
    bus.stage3_rs2_val     = rs2;
    bus.stage3_rd          = rd;
    bus.stage3_valid       = 1'b1;
    tick();
    bus.stage3_valid       = 1'b0;
  endtask

  task automatic checkWb(input string tag, input logic en, input logic [63:0] data,
                         input logic fault);
    checkOutput({tag, "_wb_valid"}, 64'(bus.wb_valid), 64'd1);
    checkOutput({tag, "_wb_en"},    64'(bus.wb_en),    64'(en));
    checkOutput({tag, "_wb_data"},  bus.wb_data,       data);
    checkOutput({tag, "_wb_fault"}, 64'(bus.wb_fault), 64'(fault));
  endtask

  // Zero-wait load: handshake now, response in the next cycle.
  task automatic serviceLoad(input string tag, input logic [63:0] rdata);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    checkOutput({tag, "_resp_no_req"}, 64'(bus.mem_req_valid), 64'd0);
    checkOutput({tag, "_resp_no_wb"},  64'(bus.wb_valid),      64'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = rdata;
    tick();
    bus.mem_resp_valid = 1'b0;
  endtask

  initial begin
    reset_n                = 1'b0;
    bus.stage3_valid       = 1'b0;
    bus.stage3_alu_result  = '0;
    bus.stage3_rs2_val     = '0;
    bus.stage3_rd          = '0;
    bus.stage3_opcode_name = '0;
    bus.mem_req_ready      = 1'b0;
    bus.mem_resp_valid     = 1'b0;
    bus.mem_resp_rdata     = '0;
    bus.wb_ready           = 1'b1;
    repeat (2) tick();

    $display("[TB] reset values");
    checkOutput("rst_ready",     64'(bus.stage3_ready),  64'd1);
    checkOutput("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    checkOutput("rst_wb_valid",  64'(bus.wb_valid),      64'd0);
    checkOutput("rst_wb_en",     64'(bus.wb_en),         64'd0);
    checkOutput("rst_wb_fault",  64'(bus.wb_fault),      64'd0);
    checkOutput("rst_wb_data",   bus.wb_data,            64'd0);
    checkOutput("rst_req_addr",  bus.mem_req_addr,       64'd0);
    checkOutput("rst_wstrb",     64'(bus.mem_req_wstrb), 64'd0);
    reset_n = 1'b1;
    tick();

    $display("[TB] addi passes the ALU result");
    reqBase = reqCount;
    applyStimulus(opName_t'("addi"), 64'h1234, 64'h0, 6'd5);
    checkWb("addi", 1'b1, 64'h1234, 1'b0);
    checkOutput("addi_wb_rd",   64'(bus.wb_rd),         64'd5);
    checkOutput("addi_no_req",  64'(bus.mem_req_valid), 64'd0);
    checkOutput("addi_busy",    64'(bus.stage3_ready),  64'd0);
    tick();
    checkOutput("addi_done",    64'(bus.wb_valid),      64'd0);
    checkOutput("addi_req_cnt", 64'(reqCount - reqBase), 64'd0);

    $display("[TB] sb lane 3");
    applyStimulus(opName_t'("sb"), 64'h1003, 64'hAB, 6'd7);
    checkOutput("sb_req_valid", 64'(bus.mem_req_valid), 64'd1);
    checkOutput("sb_addr",      bus.mem_req_addr,       64'h1000);
    checkOutput("sb_write",     64'(bus.mem_req_write), 64'd1);
    checkOutput("sb_wstrb",     64'(bus.mem_req_wstrb), 64'h08);
    checkOutput("sb_wdata",     bus.mem_req_wdata,      64'hAB00_0000);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    checkWb("sb", 1'b0, 64'h0, 1'b0);
    checkOutput("sb_req_gone",  64'(bus.mem_req_valid), 64'd0);
    tick();

    $display("[TB] sw lane 4");
    applyStimulus(opName_t'("sw"), 64'h5004, 64'hFFFF_FFFF_DEAD_BEEF, 6'd1);
    checkOutput("sw_addr",  bus.mem_req_addr,       64'h5000);
    checkOutput("sw_wstrb", 64'(bus.mem_req_wstrb), 64'hF0);
    checkOutput("sw_wdata", bus.mem_req_wdata,      64'hDEAD_BEEF_0000_0000);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    checkWb("sw", 1'b0, 64'h0, 1'b0);
    tick();

    $display("[TB] lb / lbu sign and zero extension");
    applyStimulus(opName_t'("lb"), 64'h2006, 64'h0, 6'd10);
    checkOutput("lb_addr",  bus.mem_req_addr,       64'h2000);
    checkOutput("lb_write", 64'(bus.mem_req_write), 64'd0);
    checkOutput("lb_wstrb", 64'(bus.mem_req_wstrb), 64'h00);
    serviceLoad("lb", 64'h0080_0000_0000_0000);
    checkWb("lb", 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    checkOutput("lb_wb_rd", 64'(bus.wb_rd), 64'd10);
    tick();
    applyStimulus(opName_t'("lbu"), 64'h2006, 64'h0, 6'd11);
    serviceLoad("lbu", 64'h0080_0000_0000_0000);
    checkWb("lbu", 1'b1, 64'h80, 1'b0);
    tick();

    $display("[TB] lw with request and response stalls");
    reqBase = reqCount;
    applyStimulus(opName_t'("lw"), 64'h4004, 64'h0, 6'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput("lw_stall_req",   64'(bus.mem_req_valid), 64'd1);
      checkOutput("lw_stall_busy",  64'(bus.stage3_ready),  64'd0);
      checkOutput("lw_stall_addr",  bus.mem_req_addr,       64'h4000);
      tick();
    end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    checkOutput("lw_wait_busy",  64'(bus.stage3_ready),  64'd0);
    checkOutput("lw_wait_noreq", 64'(bus.mem_req_valid), 64'd0);
    tick();
    checkOutput("lw_wait_nowb",  64'(bus.wb_valid),      64'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'h89AB_CDEF_1234_5678;
    tick();
    bus.mem_resp_valid = 1'b0;
    checkWb("lw", 1'b1, 64'hFFFF_FFFF_89AB_CDEF, 1'b0);
    checkOutput("lw_req_cnt", 64'(reqCount - reqBase), 64'd1);
    tick();

    $display("[TB] misaligned accesses");
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    reqBase = reqCount;
    applyStimulus(opName_t'("lh"), 64'h3001, 64'h0, 6'd4);
    checkWb("lh_mis", 1'b0, 64'h3001, 1'b1);
    checkOutput("lh_mis_noreq", 64'(bus.mem_req_valid), 64'd0);
    tick();
    applyStimulus(opName_t'("sd"), 64'h6005, 64'h1122_3344_5566_7788, 6'd4);
    checkWb("sd_mis", 1'b0, 64'h6005, 1'b1);
    tick();
    checkOutput("mis_req_cnt", 64'(reqCount - reqBase), 64'd0);
`else
    applyStimulus(opName_t'("lh"), 64'h3001, 64'h0, 6'd4);
    checkOutput("lh_mis_addr",  bus.mem_req_addr,       64'h3000);
    checkOutput("lh_mis_wstrb", 64'(bus.mem_req_wstrb), 64'h00);
    serviceLoad("lh_mis", 64'h0000_0000_0098_7600);
    checkWb("lh_mis", 1'b1, 64'hFFFF_FFFF_FFFF_9876, 1'b0);
    tick();
    applyStimulus(opName_t'("sd"), 64'h6005, 64'h1122_3344_5566_7788, 6'd4);
    checkOutput("sd_mis_addr",  bus.mem_req_addr,       64'h6000);
    checkOutput("sd_mis_wstrb", 64'(bus.mem_req_wstrb), 64'hE0);
    checkOutput("sd_mis_wdata", bus.mem_req_wdata,      64'h6677_8800_0000_0000);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    checkWb("sd_mis", 1'b0, 64'h0, 1'b0);
    tick();
`endif

    $display("[TB] no-write class and rd == 0");
    applyStimulus(opName_t'("beq"), 64'h1, 64'h0, 6'd6);
    checkWb("beq", 1'b0, 64'h0, 1'b0);
    tick();
    applyStimulus(opName_t'("bogus"), 64'h77, 64'h0, 6'd6);
    checkWb("unknown", 1'b0, 64'h0, 1'b0);
    tick();
    applyStimulus(opName_t'("add"), 64'h42, 64'h0, 6'd0);
    checkWb("add_rd0", 1'b0, 64'h42, 1'b0);
    tick();

    $display("[TB] writeback back-pressure");
    bus.wb_ready = 1'b0;
    applyStimulus(opName_t'("sub"), 64'h99, 64'h0, 6'd2);
    checkWb("sub_stall0", 1'b1, 64'h99, 1'b0);
    tick();
    checkWb("sub_stall1", 1'b1, 64'h99, 1'b0);
    checkOutput("sub_stall_busy", 64'(bus.stage3_ready), 64'd0);
    bus.wb_ready = 1'b1;
    tick();
    checkOutput("sub_released", 64'(bus.wb_valid), 64'd0);

    $display("[TB] reset while waiting for a response");
    applyStimulus(opName_t'("ld"), 64'h7000, 64'h0, 6'd8);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("rst2_ready",     64'(bus.stage3_ready),  64'd1);
    checkOutput("rst2_req_valid", 64'(bus.mem_req_valid), 64'd0);
    checkOutput("rst2_wb_valid",  64'(bus.wb_valid),      64'd0);
    checkOutput("rst2_wb_en",     64'(bus.wb_en),         64'd0);
    checkOutput("rst2_addr",      bus.mem_req_addr,       64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.mem_resp_valid = 1'b0;
    checkOutput("stray_resp_nowb",  64'(bus.wb_valid),     64'd0);
    checkOutput("stray_resp_ready", 64'(bus.stage3_ready), 64'd1);
    checkOutput("stray_resp_data",  bus.wb_data,           64'd0);
    applyStimulus(opName_t'("add"), 64'h55, 64'h0, 6'd9);
    checkWb("add_after_rst", 1'b1, 64'h55, 1'b0);
    checkOutput("add_after_rst_rd", 64'(bus.wb_rd), 64'd9);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
